// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan codes to ASCII: pops the receiver FIFO, tracks E0/F0/Shift/CapsLock,
// and buffers translated characters for the CPU. One code per 3 cycles; push lands at the DECODE edge.
module ps2_ascii_decoder #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  output logic       ps2_rdn,
  input  logic       rd,
  output logic [7:0] ascii,
  output logic       valid,
  output logic       overflow,
  output logic       shift,
  output logic       caps
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

  state_t                state, state_n;
  logic [7:0]            code, code_n;
  logic                  rdn_n, ext, ext_n, brk, brk_n, shift_n, caps_n, push;
  logic [8:0]            map;
  logic [7:0]            mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  pop, full, wr;

  // Returns {hit, ascii}; letters fold to uppercase when upper is set.
  function automatic logic [8:0] scan_map(input logic [7:0] c, input logic upper);
    logic [7:0] ch;
    logic       hit, letter;
    ch = 8'h00; hit = 1'b1; letter = 1'b1;
    case (c)
      8'h1C: ch = 8'h61; 8'h32: ch = 8'h62; 8'h21: ch = 8'h63; 8'h23: ch = 8'h64;
      8'h24: ch = 8'h65; 8'h2B: ch = 8'h66; 8'h34: ch = 8'h67; 8'h33: ch = 8'h68;
      8'h43: ch = 8'h69; 8'h3B: ch = 8'h6A; 8'h42: ch = 8'h6B; 8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D; 8'h31: ch = 8'h6E; 8'h44: ch = 8'h6F; 8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71; 8'h2D: ch = 8'h72; 8'h1B: ch = 8'h73; 8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75; 8'h2A: ch = 8'h76; 8'h1D: ch = 8'h77; 8'h22: ch = 8'h78;
      8'h35: ch = 8'h79; 8'h1A: ch = 8'h7A;
      default: begin
        letter = 1'b0;
        case (c)
          8'h45: ch = 8'h30; 8'h16: ch = 8'h31; 8'h1E: ch = 8'h32; 8'h26: ch = 8'h33;
          8'h25: ch = 8'h34; 8'h2E: ch = 8'h35; 8'h36: ch = 8'h36; 8'h3D: ch = 8'h37;
          8'h3E: ch = 8'h38; 8'h46: ch = 8'h39;
          8'h29: ch = 8'h20; 8'h5A: ch = 8'h0D; 8'h66: ch = 8'h08;
          default: hit = 1'b0;
        endcase
      end
    endcase
    if (letter && upper) ch = ch - 8'h20;
    return {hit, ch};
  endfunction

  assign map = scan_map(code, shift ^ caps);

  always_comb begin
    state_n = state;
    code_n  = code;
    rdn_n   = 1'b1;
    ext_n   = ext;
    brk_n   = brk;
    shift_n = shift;
    caps_n  = caps;
    push    = 1'b0;
    case (state)
      IDLE: if (ps2_ready) begin
        code_n  = ps2_data;
        rdn_n   = 1'b0;
        state_n = POP;
      end
      POP: state_n = DECODE;
      DECODE: begin
        state_n = IDLE;
        if (code == 8'hE0) ext_n = 1'b1;
        else if (code == 8'hF0) brk_n = 1'b1;
        else begin
          ext_n = 1'b0;
          brk_n = 1'b0;
          if ((code == 8'h12 || code == 8'h59) && !ext) shift_n = ~brk;
          else if (code == 8'h58 && !brk && !ext)    caps_n  = ~caps;
          else if (!ext && !brk && map[8])           push    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= IDLE;
      code    <= 8'h00;
      ps2_rdn <= 1'b1;
      ext     <= 1'b0;
      brk     <= 1'b0;
      shift   <= 1'b0;
      caps    <= 1'b0;
    end else begin
      state   <= state_n;
      code    <= code_n;
      ps2_rdn <= rdn_n;
      ext     <= ext_n;
      brk     <= brk_n;
      shift   <= shift_n;
      caps    <= caps_n;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop  = rd && (count != '0);
  assign full = (count == FULL_CNT);
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (!wr && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn && wr) mem[wptr] <= map[7:0];
  end

  assign valid = (count != '0);
  assign ascii = valid ? mem[rptr] : 8'h00;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder; inputs driven and outputs sampled on the falling edge.
module tb_ps2_ascii_decoder;

  logic       clk, clrn, ps2_ready, rd;
  logic [7:0] ps2_data;
  logic       ps2_rdn, valid, overflow, shift, caps;
  logic [7:0] ascii;
  int         n_err = 0;
  int         n_chk = 0;

  ps2_ascii_decoder #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .clrn(clrn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_rdn(ps2_rdn), .rd(rd), .ascii(ascii), .valid(valid),
    .overflow(overflow), .shift(shift), .caps(caps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one code, wait for the pop strobe, then let POP/DECODE complete.
  task automatic feed(input logic [7:0] c, input bit rd_at_decode);
    int n;
    ps2_data  = c;
    ps2_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ps2_rdn !== 1'b0 && n < 20);
    chk("pop_strobe", {7'b0, ps2_rdn}, 8'h00);
    ps2_ready = 1'b0;
    @(negedge clk);
    if (rd_at_decode) rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic read_char(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {7'b0, valid}, 8'h01);
    chk(tag, ascii, exp);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    clrn = 1'b0; ps2_ready = 1'b0; ps2_data = 8'h00; rd = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_valid", {7'b0, valid}, 8'h00);
    chk("rst_ascii", ascii, 8'h00);
    chk("rst_rdn", {7'b0, ps2_rdn}, 8'h01);
    chk("rst_ovf", {7'b0, overflow}, 8'h00);
    chk("rst_shift", {7'b0, shift}, 8'h00);
    chk("rst_caps", {7'b0, caps}, 8'h00);

    // single 'a' with latency and strobe width
    ps2_data = 8'h1C; ps2_ready = 1'b1;
    @(negedge clk);
    chk("lat_rdn_low", {7'b0, ps2_rdn}, 8'h00);
    chk("lat_valid_e1", {7'b0, valid}, 8'h00);
    ps2_ready = 1'b0;
    @(negedge clk);
    chk("lat_rdn_high", {7'b0, ps2_rdn}, 8'h01);
    chk("lat_valid_e2", {7'b0, valid}, 8'h00);
    @(negedge clk);
    read_char("a_char", 8'h61);
    chk("a_empty_valid", {7'b0, valid}, 8'h00);
    chk("a_empty_ascii", ascii, 8'h00);
    rd = 1'b1;  // read while empty is ignored
    @(negedge clk);
    rd = 1'b0;
    chk("underflow_valid", {7'b0, valid}, 8'h00);

    // shift handling
    feed(8'h12, 0);
    chk("shift_on", {7'b0, shift}, 8'h01);
    feed(8'h1C, 0); feed(8'hF0, 0); feed(8'h1C, 0); feed(8'hF0, 0);
    chk("shift_held", {7'b0, shift}, 8'h01);
    feed(8'h12, 0);
    chk("shift_off", {7'b0, shift}, 8'h00);
    feed(8'h1C, 0);
    read_char("shift_A", 8'h41);
    read_char("shift_a", 8'h61);
    chk("shift_empty", {7'b0, valid}, 8'h00);

    // capslock toggling
    feed(8'h58, 0);
    chk("caps_on", {7'b0, caps}, 8'h01);
    feed(8'hF0, 0); feed(8'h58, 0);
    chk("caps_brk_ignored", {7'b0, caps}, 8'h01);
    feed(8'h32, 0);
    feed(8'h58, 0);
    chk("caps_off", {7'b0, caps}, 8'h00);
    feed(8'hF0, 0); feed(8'h58, 0);
    chk("caps_brk2", {7'b0, caps}, 8'h00);
    feed(8'h32, 0);
    read_char("caps_B", 8'h42);
    read_char("caps_b", 8'h62);

    // extended codes produce nothing
    feed(8'hE0, 0); feed(8'h75, 0);
    feed(8'hE0, 0); feed(8'hF0, 0); feed(8'h75, 0);
    chk("ext_nothing", {7'b0, valid}, 8'h00);
    feed(8'h45, 0);
    read_char("digit0", 8'h30);
    chk("ext_empty", {7'b0, valid}, 8'h00);
    feed(8'hE0, 0); feed(8'h12, 0);
    chk("ext_shift", {7'b0, shift}, 8'h00);

    // overflow: 9 pushes into 8 slots
    for (int i = 0; i < 9; i++) feed(8'h16, 0);
    chk("ovf_set", {7'b0, overflow}, 8'h01);
    for (int i = 0; i < 8; i++) read_char("ovf_read", 8'h31);
    chk("ovf_drained", {7'b0, valid}, 8'h00);
    chk("ovf_sticky", {7'b0, overflow}, 8'h01);

    // full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) feed(8'h16, 0);
    feed(8'h1E, 1);
    chk("full_pp_ovf", {7'b0, overflow}, 8'h00);
    for (int i = 0; i < 7; i++) read_char("full_pp_1", 8'h31);
    read_char("full_pp_2", 8'h32);
    chk("full_pp_empty", {7'b0, valid}, 8'h00);

    // reset while in POP
    feed(8'h58, 0);
    for (int i = 0; i < 9; i++) feed(8'h1C, 0);
    chk("pre_rst_ovf", {7'b0, overflow}, 8'h01);
    chk("pre_rst_caps", {7'b0, caps}, 8'h01);
    ps2_data = 8'h1C; ps2_ready = 1'b1;
    @(negedge clk);
    chk("mid_pop_rdn", {7'b0, ps2_rdn}, 8'h00);
    clrn = 1'b0; ps2_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {7'b0, valid}, 8'h00);
    chk("mid_rst_ascii", ascii, 8'h00);
    chk("mid_rst_caps", {7'b0, caps}, 8'h00);
    chk("mid_rst_ovf", {7'b0, overflow}, 8'h00);
    chk("mid_rst_rdn", {7'b0, ps2_rdn}, 8'h01);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_push", {7'b0, valid}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
